eq_seq8: RTL and testbench
==========================

# eq_seq8

Byte-serial equality comparator for wide operands. It reuses a single 8-bit compare slice over several clock cycles instead of instantiating one slice per byte. The cascade signal that would normally pass between chained slices is carried from one cycle to the next in a mismatch register. The block sits beside the combinational wide-compare mapping and is used where area or chip count matters more than latency. Start/busy/done handshake.

## Interface
- `WIDTH`, default 32: operand width in bits, ≥1. Operands are zero-padded internally to `NBYTES*8`, where `NBYTES = (WIDTH+7)/8`.
- `EARLY_EXIT`, default 0: 1 ends the compare on the first mismatching byte; 0 always scans all bytes.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: request a compare; sampled only in IDLE.
- `a`  in  `WIDTH`: operand A; captured on the accepted start edge.
- `b`  in  `WIDTH`: operand B; captured on the accepted start edge.
- `busy`  out  1: high while in the CMP state.
- `done`  out  1: one-cycle pulse when a result is written.
- `eq`  out  1: registered result, A==B; held until the next result or reset.
- `ne`  out  1: registered result, A!=B; always `!eq` once a result exists.

## Operation
- States are IDLE and CMP, with byte index `idx` (0..NBYTES-1) and mismatch register `miss`.
- **IDLE**
  - On `start` = 1: latch the padded `a` and `b`, set `idx` = 0 and `miss` = 0, go to CMP.
  - On `start` = 0: stay in IDLE.
- **CMP, each cycle**
  - `miss_n = miss | (A[idx*8+:8] != B[idx*8+:8])`.
  - Bytes are scanned LSB byte first.
- **Termination**
  - Terminate when `idx == NBYTES-1`, or when `EARLY_EXIT` = 1 and `miss_n` = 1.
  - On termination: `eq <= !miss_n`, `ne <= miss_n`, `done <= 1`, go to IDLE.
  - Otherwise: `idx <= idx+1`, `miss <= miss_n`.
- `start` while in CMP is ignored; there is no queueing.
- `start` in the same cycle `done` is high is accepted, because the state is already IDLE.
- Changes on `a`/`b` after the capture edge do not affect the running compare.
- Padding bits are zero in both operands and never cause a mismatch.
  - `WIDTH=12` compares bits [11:0] only.
- `done` is cleared every cycle it is not being set.
- **Reset:** overrides everything, including a compare in progress.
  - State goes to IDLE; `busy` = 0, `done` = 0, `eq` = 0, `ne` = 0; `idx` = 0, `miss` = 0.
  - The aborted compare produces no `done`.
  - `eq` = `ne` = 0 after reset means "no result yet".

## Timing
- Accepted `start` is sampled at edge 0. `busy` is high in cycles 1..K, where K is the number of bytes scanned.
- **Without early exit:** K = `NBYTES`.
- **With `EARLY_EXIT` = 1:** K = index of the first mismatching byte + 1. If all bytes match, K = `NBYTES`.
- `done` is high in cycle K+1 only. `eq`/`ne` update at the same edge that raises `done`.
- **Latency:** start to `done` is K+1 cycles.
- **Throughput:** one compare per K+1 cycles if `start` is held high continuously.
- `WIDTH` ≤ 8 gives K = 1, so `done` arrives 2 cycles after `start`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **All bytes equal, full scan:** `WIDTH`=32, `EARLY_EXIT`=0, `a`=`b`=0xDEADBEEF, start pulse.
  - `busy` high for 4 cycles.
  - `done` in cycle 5 with `eq`=1, `ne`=0.
- **Top-byte mismatch, full scan:** `WIDTH`=32, `EARLY_EXIT`=0, `a`=0x12345678, `b`=0x92345678.
  - `done` in cycle 5, `eq`=0, `ne`=1.
  - Then a 0xFF vs 0xFF compare → `eq` returns to 1.
- **Early exit:** `EARLY_EXIT`=1, `WIDTH`=32, `a`=0x000000AA, `b`=0x000000AB.
  - `busy` high 1 cycle, `done` in cycle 2, `ne`=1.
  - Same operands with `EARLY_EXIT`=0 → `done` in cycle 5.
- **Ignored start and operand capture:** pulse `start` again in cycle 2 of a 4-byte compare, and change `a`/`b` after the capture edge.
  - Exactly one `done`, in cycle 5.
  - Result reflects the operands captured at the first start.
- **Padding:** `WIDTH`=12, `a`=0xFFF, `b`=0xFFF.
  - `busy` 2 cycles, `eq`=1.
  - `a`=0x7FF vs `b`=0xFFF → `ne`=1.
- **Reset mid-compare:** assert `rst` in cycle 2 of a 4-byte compare.
  - Next cycle: `busy`=0, `eq`=`ne`=0, and no `done` for the aborted compare.
  - A new `start` then completes normally in 5 cycles.

Source files
------------

// File: rtl/eq_seq8.sv
// eq_seq8: byte-serial A==B comparator reusing one 8-bit slice, with start/busy/done handshake.
module eq_seq8 #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             ne
);
    localparam int NBYTES = (WIDTH + 7) / 8;
    localparam int W8     = NBYTES * 8;
    localparam int IW     = NBYTES > 1 ? $clog2(NBYTES) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CMP  = 1'b1;

    logic [0:0]    state;
    logic [W8-1:0] pa, pb;
    logic [IW-1:0] idx;
    logic          miss;
    logic [7:0]    byte_a, byte_b;
    logic          miss_n, term;

    // the mismatch register stands in for the cascade input of the next slice
    always_comb begin
        byte_a = 8'(pa >> {idx, 3'b000});
        byte_b = 8'(pb >> {idx, 3'b000});
        miss_n = miss | (byte_a != byte_b);
        term   = (idx == IW'(NBYTES - 1)) | (EARLY_EXIT & miss_n);
    end

    assign busy = (state == CMP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            eq    <= 1'b0;
            ne    <= 1'b0;
            idx   <= '0;
            miss  <= 1'b0;
            pa    <= '0;
            pb    <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                pa    <= W8'(a);
                pb    <= W8'(b);
                idx   <= '0;
                miss  <= 1'b0;
                state <= CMP;
            end else if (state == CMP) begin
                if (term) begin
                    eq    <= !miss_n;
                    ne    <= miss_n;
                    done  <= 1'b1;
                    state <= IDLE;
                end else begin
                    idx  <= idx + IW'(1);
                    miss <= miss_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_eq_seq8.sv
// tb_eq_seq8: drives a 32-bit full-scan, a 32-bit early-exit and a 12-bit comparator with shared stimulus.
module tb_eq_seq8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  bsy, dn, eqv, nev;

    always #5 clk = ~clk;

    eq_seq8 #(.WIDTH(32), .EARLY_EXIT(1'b0)) d0 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(bsy[0]), .done(dn[0]), .eq(eqv[0]), .ne(nev[0]));
    eq_seq8 #(.WIDTH(32), .EARLY_EXIT(1'b1)) d1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(bsy[1]), .done(dn[1]), .eq(eqv[1]), .ne(nev[1]));
    eq_seq8 #(.WIDTH(12), .EARLY_EXIT(1'b0)) d2 (
        .clk(clk), .rst(rst), .start(start), .a(a[11:0]), .b(b[11:0]),
        .busy(bsy[2]), .done(dn[2]), .eq(eqv[2]), .ne(nev[2]));

    typedef struct {
        logic [31:0] a, b;
        logic        eq32;
        int          k1;
        logic        eq12;
    } vec_t;
    typedef struct {
        logic eq32;
        int   k1;
        logic eq12;
    } exp_t;

    vec_t tbl[8];
    exp_t q[$];
    int   n_cmp = 0, n_fail = 0;
    int   bc[3], dc[3], fd[3], ld[3];
    logic leq[3], lne[3];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // per-DUT busy cycles, done count, first/last done cycle and result at last done
    task automatic watch(input int n, input int inj, input logic [31:0] ia, input logic [31:0] ib);
        for (int i = 0; i < 3; i++) begin
            bc[i] = 0; dc[i] = 0; fd[i] = 0; ld[i] = 0; leq[i] = 1'bx; lne[i] = 1'bx;
        end
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (bsy[i]) bc[i]++;
                if (dn[i]) begin
                    dc[i]++;
                    if (fd[i] == 0) fd[i] = c;
                    ld[i] = c;
                    leq[i] = eqv[i];
                    lne[i] = nev[i];
                end
            end
            if (c == inj) begin
                a = ia; b = ib; start = 1'b1;
            end else start = 1'b0;
        end
    endtask

    task automatic run(input int v);
        exp_t e;
        q.push_back('{tbl[v].eq32, tbl[v].k1, tbl[v].eq12});
        @(negedge clk);
        a = tbl[v].a; b = tbl[v].b; start = 1'b1;
        watch(8, 0, '0, '0);
        e = q.pop_front();
        chk($sformatf("v%0d_full_busy", v), bc[0], 4);
        chk($sformatf("v%0d_full_done_cyc", v), fd[0], 5);
        chk($sformatf("v%0d_full_ndone", v), dc[0], 1);
        chk($sformatf("v%0d_full_eq", v), int'(leq[0]), int'(e.eq32));
        chk($sformatf("v%0d_full_ne", v), int'(lne[0]), int'(!e.eq32));
        chk($sformatf("v%0d_early_busy", v), bc[1], e.k1);
        chk($sformatf("v%0d_early_done_cyc", v), fd[1], e.k1 + 1);
        chk($sformatf("v%0d_early_ndone", v), dc[1], 1);
        chk($sformatf("v%0d_early_eq", v), int'(leq[1]), int'(e.eq32));
        chk($sformatf("v%0d_early_ne", v), int'(lne[1]), int'(!e.eq32));
        chk($sformatf("v%0d_w12_busy", v), bc[2], 2);
        chk($sformatf("v%0d_w12_done_cyc", v), fd[2], 3);
        chk($sformatf("v%0d_w12_ndone", v), dc[2], 1);
        chk($sformatf("v%0d_w12_eq", v), int'(leq[2]), int'(e.eq12));
        chk($sformatf("v%0d_w12_ne", v), int'(lne[2]), int'(!e.eq12));
    endtask

    initial begin
        tbl[0] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 4, 1'b1};
        tbl[1] = '{32'h12345678, 32'h92345678, 1'b0, 4, 1'b1};
        tbl[2] = '{32'h000000AA, 32'h000000AB, 1'b0, 1, 1'b0};
        tbl[3] = '{32'h00000FFF, 32'h00000FFF, 1'b1, 4, 1'b1};
        tbl[4] = '{32'h000007FF, 32'h00000FFF, 1'b0, 2, 1'b0};
        tbl[5] = '{32'h00AB0000, 32'h00CD0000, 1'b0, 3, 1'b1};
        tbl[6] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1, 1'b0};
        tbl[7] = '{32'h000000FF, 32'h000000FF, 1'b1, 4, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bsy), 0);
        chk("rst_done", int'(dn), 0);
        chk("rst_eq", int'(eqv), 0);
        chk("rst_ne", int'(nev), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(bsy), 0);

        for (int v = 0; v < 8; v++) run(v);

        // restart mid-compare with new operands: ignored, captured values win
        @(negedge clk);
        a = 32'h11223344; b = 32'h11223344; start = 1'b1;
        watch(8, 2, 32'h00000000, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ign_d%0d_ndone", i), dc[i], 1);
            chk($sformatf("ign_d%0d_eq", i), int'(leq[i]), 1);
        end
        chk("ign_full_done_cyc", fd[0], 5);
        chk("ign_early_done_cyc", fd[1], 5);
        chk("ign_w12_done_cyc", fd[2], 3);

        // start raised in the cycle done is high is accepted
        @(negedge clk);
        a = 32'hCAFEF00D; b = 32'hCAFEF00D; start = 1'b1;
        watch(12, 5, 32'h00000001, 32'h00000002);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_d%0d_ndone", i), dc[i], 2);
            chk($sformatf("b2b_d%0d_eq", i), int'(leq[i]), 0);
            chk($sformatf("b2b_d%0d_ne", i), int'(lne[i]), 1);
        end
        chk("b2b_full_first", fd[0], 5);
        chk("b2b_full_last", ld[0], 10);
        chk("b2b_early_last", ld[1], 7);
        chk("b2b_w12_first", fd[2], 3);
        chk("b2b_w12_last", ld[2], 8);

        run(7);
        chk("pre_rst_eq", int'(eqv), 7);

        // reset aborts a compare in flight
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'hDEADBEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(bsy), 0);
        chk("abort_eq", int'(eqv), 0);
        chk("abort_ne", int'(nev), 0);
        chk("abort_done", int'(dn), 0);
        rst = 1'b0;
        watch(6, 0, '0, '0);
        for (int i = 0; i < 3; i++) chk($sformatf("abort_d%0d_ndone", i), dc[i], 0);

        run(0);
        run(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
